// File: rtl/manrx_pkg.sv
// ============================================================================
// manrx_pkg : shared types, window-bound helpers and PRBS7 constants for the
//             oversampling Manchester receiver.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package manrx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } manrx_state_e;

  function automatic int mid_lo(input int ovs, input int tol);
    return ovs - tol;
  endfunction

  function automatic int mid_hi(input int ovs, input int tol);
    return ovs + tol;
  endfunction

  function automatic int bnd_lo(input int ovs, input int tol);
    return ovs / 2 - tol;
  endfunction

  function automatic int bnd_hi(input int ovs, input int tol);
    return ovs / 2 + tol;
  endfunction

  function automatic int ph_max(input int ovs, input int tol);
    return ovs + tol + 1;
  endfunction

  // PRBS7, x^7 + x^6 + 1
  localparam int PRBS_LEN      = 7;
  localparam int PRBS_TAP_A    = 6;
  localparam int PRBS_TAP_B    = 5;
  localparam int PRBS_SYNC_RUN = 16;

endpackage

`default_nettype wire

// File: rtl/manrx_edge_det.sv
// ============================================================================
// manrx_edge_det : multi-stage synchronizer for the Manchester line with
//                  edge strobe and synchronized level outputs.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module manrx_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic code_i,
  output logic edge_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], code_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/manchester_rx_os.sv
// ============================================================================
// manchester_rx_os : oversampling Manchester decoder (HUNT/ACQ/TRACK lock FSM,
//                    phase counter, optional PRBS7 checker via MANRX_PRBS_CHECK_EN).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module manchester_rx_os
  import manrx_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        code_in,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        bit_clk,
  output logic        locked,
  output logic        fail
`ifdef MANRX_PRBS_CHECK_EN
  ,
  output logic        prbs_sync,
  output logic [15:0] prbs_err_cnt
`endif
);

  localparam int             PW     = $clog2(OVS + TOL + 2);
  localparam logic [PW-1:0]  MID_LO = PW'(mid_lo(OVS, TOL));
  localparam logic [PW-1:0]  MID_HI = PW'(mid_hi(OVS, TOL));
  localparam logic [PW-1:0]  BND_LO = PW'(bnd_lo(OVS, TOL));
  localparam logic [PW-1:0]  BND_HI = PW'(bnd_hi(OVS, TOL));
  localparam logic [PW-1:0]  PH_MAX = PW'(ph_max(OVS, TOL));
  localparam logic [PW-1:0]  HALF   = PW'(OVS / 2);

  manrx_state_e  state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          bit_q, bit_d;
  logic          valid_q, valid_d;
  logic          fail_q, fail_d;

  logic          w_edge;
  logic          w_level;
  logic [PW-1:0] w_ph;
  logic          w_in_mid;
  logic          w_in_bnd;
  logic          w_timeout;

  manrx_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .code_i  (code_in),
    .edge_o  (w_edge),
    .level_o (w_level)
  );

  // w_ph is the phase of the current cycle, so an edge N clk after the anchor sees phase N
  assign w_ph      = (phase_q == PH_MAX) ? PH_MAX : phase_q + PW'(1);
  assign w_in_mid  = (w_ph >= MID_LO) && (w_ph <= MID_HI);
  assign w_in_bnd  = (w_ph >= BND_LO) && (w_ph <= BND_HI);
  assign w_timeout = (w_ph > MID_HI);

  always_comb begin
    state_d = state_q;
    phase_d = w_ph;
    bit_d   = bit_q;
    valid_d = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (w_edge) begin
          state_d = ACQ;
          phase_d = '0;
        end
      end
      ACQ: begin
        if (w_edge) begin
          phase_d = '0;
          if (w_in_mid) begin
            state_d = TRACK;
            valid_d = 1'b1;
            bit_d   = ~w_level;
          end
        end else if (w_timeout) begin
          state_d = HUNT;
        end
      end
      TRACK: begin
        if (w_edge) begin
          if (w_in_mid) begin
            valid_d = 1'b1;
            bit_d   = ~w_level;
            phase_d = '0;
          end else if (!w_in_bnd) begin
            fail_d  = 1'b1;
            state_d = HUNT;
          end
        end else if (w_timeout) begin
          fail_d  = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      phase_q <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = valid_q;
  assign fail      = fail_q;
  assign locked    = (state_q == TRACK);
  assign bit_clk   = locked && (phase_q < HALF);

`ifdef MANRX_PRBS_CHECK_EN
  logic [PRBS_LEN-1:0] sr_q, sr_d;
  logic [4:0]          mcnt_q, mcnt_d;
  logic                sync_q, sync_d;
  logic [15:0]         err_q, err_d;
  logic                w_pred;

  assign w_pred = sr_q[PRBS_TAP_A] ^ sr_q[PRBS_TAP_B];

  always_comb begin
    sr_d   = sr_q;
    mcnt_d = mcnt_q;
    sync_d = sync_q;
    err_d  = err_q;
    if (valid_q) begin
      sr_d = {sr_q[PRBS_LEN-2:0], bit_q};
      if (w_pred == bit_q) begin
        if (mcnt_q != 5'(PRBS_SYNC_RUN)) mcnt_d = mcnt_q + 5'd1;
        if (mcnt_q == 5'(PRBS_SYNC_RUN - 1)) sync_d = 1'b1;
      end else begin
        mcnt_d = '0;
        if (sync_q && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      end
    end
    // Loss of lock invalidates the sequence alignment; the error count persists
    if (state_q != TRACK) begin
      sync_d = 1'b0;
      mcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      mcnt_q <= '0;
      sync_q <= 1'b0;
      err_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      mcnt_q <= mcnt_d;
      sync_q <= sync_d;
      err_q  <= err_d;
    end
  end

  assign prbs_sync    = sync_q;
  assign prbs_err_cnt = err_q;
`endif

endmodule

`default_nettype wire
